// File: rtl/mapper_pkg.sv
// Shared types and default geometry for the banked address mapper.
package mapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFRESH = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int MAP_W = 1;
  localparam int SLOTS = 8;
  localparam int OFF_W = 12;

  function automatic int map_width(input int num_maps);
    return (num_maps > 2) ? $clog2(num_maps) : 1;
  endfunction

endpackage

// File: rtl/mapper_fast_table.sv
// Flat lookup table of {enable, offset} per (map, slot): one synchronous write
// port fed by the refresh engine and one combinational read port for translation.
module mapper_fast_table #(
  parameter int IDX_W     = 4,
  parameter int TBL_OFF_W = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_waddr,
  input  logic [TBL_OFF_W-1:0] i_woffset,
  input  logic                 i_wenable,
  input  logic [IDX_W-1:0]     i_raddr,
  output logic [TBL_OFF_W-1:0] o_roffset,
  output logic                 o_renable
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [TBL_OFF_W-1:0] r_off [ENTRIES];
  logic                 r_en  [ENTRIES];

  // Table storage, cleared to disabled/zero on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_off[i] <= '0;
        r_en[i]  <= 1'b0;
      end
    end else if (i_we) begin
      r_off[i_waddr] <= i_woffset;
      r_en[i_waddr]  <= i_wenable;
    end
  end

  assign o_roffset = r_off[i_raddr];
  assign o_renable = r_en[i_raddr];

endmodule

// File: rtl/mapper_banked.sv
// Banked CPU-to-physical address mapper: architectural slot registers, a refresh
// engine that copies one map set into the fast table, and the translation adder.
module mapper_banked
  import mapper_pkg::*;
#(
  parameter int                         CPU_AW      = 16,
  parameter int                         PHYS_AW     = 20,
  parameter int                         SLOT_BITS   = 3,
  parameter int                         NUM_MAPS    = 2,
  parameter logic [(1<<SLOT_BITS)-1:0]  RST_ENABLES = 8'h30,
  parameter logic [PHYS_AW-9:0]         RST_OFFSET  = 12'hF00
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ready,
  input  logic [CPU_AW-1:0]               core_address_next,
  input  logic [map_width(NUM_MAPS)-1:0]  active_map,
  input  logic                            cfg_we,
  input  logic [map_width(NUM_MAPS)-1:0]  cfg_map,
  input  logic [SLOT_BITS-1:0]            cfg_slot,
  input  logic [PHYS_AW-9:0]              cfg_offset,
  input  logic                            cfg_enable,
  input  logic                            cfg_commit,
  output logic [PHYS_AW-9:0]              rd_offset,
  output logic                            rd_enable,
  output logic                            busy,
  output logic                            commit_done,
  output logic [PHYS_AW-1:0]              address_next,
  output logic                            map_next,
  output logic [PHYS_AW-1:0]              address,
  output logic                            map
);

  localparam int MAP_W_L = map_width(NUM_MAPS);
  localparam int SLOTS_L = 1 << SLOT_BITS;
  localparam int OFF_W_L = PHYS_AW - 8;
  localparam int IDX_W   = MAP_W_L + SLOT_BITS;
  localparam int ENTRIES = 1 << IDX_W;

  logic [OFF_W_L-1:0]   r_arch_off [ENTRIES];
  logic                 r_arch_en  [ENTRIES];
  state_e               r_state;
  state_e               w_state_nxt;
  logic [SLOT_BITS-1:0] r_cnt, w_cnt_nxt;
  logic [MAP_W_L-1:0]   r_cur, w_cur_nxt, w_pick;
  logic                 r_quiet, w_quiet_nxt;
  logic [NUM_MAPS-1:0]  r_pending, r_boot, w_set, w_clr;
  logic                 w_fast_we;
  logic                 r_commit_done;
  logic [PHYS_AW-1:0]   r_address, w_addr_nxt;
  logic                 r_map, w_map_nxt;
  logic [IDX_W-1:0]     w_ref_idx, w_lookup_idx, w_rd_idx;
  logic [OFF_W_L-1:0]   w_fast_woff, w_fast_off, w_hi, w_sum;
  logic                 w_fast_en;

  assign w_rd_idx     = {cfg_map, cfg_slot};
  assign w_ref_idx    = {r_cur, r_cnt};
  assign w_lookup_idx = {active_map, core_address_next[CPU_AW-1 -: SLOT_BITS]};
  assign w_set        = cfg_commit ? (NUM_MAPS'(1) << cfg_map) : '0;

  // Architectural slot registers; the last map boots with the reset windows enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_arch_en[i]  <= ((i >> SLOT_BITS) == NUM_MAPS - 1) && RST_ENABLES[i & (SLOTS_L - 1)];
        r_arch_off[i] <= (((i >> SLOT_BITS) == NUM_MAPS - 1) && RST_ENABLES[i & (SLOTS_L - 1)])
                         ? RST_OFFSET : '0;
      end
    end else if (cfg_we) begin
      r_arch_off[w_rd_idx] <= cfg_offset;
      r_arch_en[w_rd_idx]  <= cfg_enable;
    end
  end

  assign rd_offset = r_arch_off[w_rd_idx];
  assign rd_enable = r_arch_en[w_rd_idx];

  // Lowest pending map wins.
  always_comb begin
    w_pick = '0;
    for (int m = NUM_MAPS - 1; m >= 0; m--) begin
      w_pick = r_pending[m] ? MAP_W_L'(m) : w_pick;
    end
  end

  // Refresh engine next-state; boot-time passes end without a commit_done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_quiet_nxt = r_quiet;
    w_clr       = '0;
    w_fast_we   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_clr       = NUM_MAPS'(1) << w_pick;
          w_cur_nxt   = w_pick;
          w_cnt_nxt   = '0;
          w_quiet_nxt = r_boot[w_pick];
          w_state_nxt = ST_REFRESH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        w_fast_we = 1'b1;
        if (r_pending[r_cur]) begin
          w_clr       = NUM_MAPS'(1) << r_cur;
          w_cnt_nxt   = '0;
          w_quiet_nxt = 1'b0;
        end else if (r_cnt == SLOT_BITS'(SLOTS_L - 1)) begin
          w_state_nxt = r_quiet ? ST_IDLE : ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + SLOT_BITS'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Refresh engine state; a new commit outranks a same-cycle clear of its pending bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cur         <= '0;
      r_quiet       <= 1'b0;
      r_pending     <= '1;
      r_boot        <= '1;
      r_commit_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cur         <= w_cur_nxt;
      r_quiet       <= w_quiet_nxt;
      r_pending     <= (r_pending & ~w_clr) | w_set;
      r_boot        <= r_boot & ~w_clr & ~w_set;
      r_commit_done <= (r_state == ST_DONE);
    end
  end

  assign busy        = (r_state != ST_IDLE) || (|r_pending);
  assign commit_done = r_commit_done;
  assign w_fast_woff = r_arch_en[w_ref_idx] ? r_arch_off[w_ref_idx] : '0;

  mapper_fast_table #(
    .IDX_W     (IDX_W),
    .TBL_OFF_W (OFF_W_L)
  ) u_fast (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_we      (w_fast_we),
    .i_waddr   (w_ref_idx),
    .i_woffset (w_fast_woff),
    .i_wenable (r_arch_en[w_ref_idx]),
    .i_raddr   (w_lookup_idx),
    .o_roffset (w_fast_off),
    .o_renable (w_fast_en)
  );

  assign w_hi  = OFF_W_L'(core_address_next[CPU_AW-1:8]);
  assign w_sum = w_fast_off + w_hi;

  // Translation; a stalled CPU cycle presents the held registered result.
  always_comb begin
    if (!ready) begin
      w_addr_nxt = r_address;
      w_map_nxt  = r_map;
    end else if (w_fast_en) begin
      w_addr_nxt = {w_sum, core_address_next[7:0]};
      w_map_nxt  = 1'b1;
    end else begin
      w_addr_nxt = PHYS_AW'(core_address_next);
      w_map_nxt  = 1'b0;
    end
  end

  // Registered translation, advancing only on ready cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_address <= '0;
      r_map     <= 1'b0;
    end else if (ready) begin
      r_address <= w_addr_nxt;
      r_map     <= w_map_nxt;
    end
  end

  assign address_next = w_addr_nxt;
  assign map_next     = w_map_nxt;
  assign address      = r_address;
  assign map          = r_map;

endmodule

// File: tb/tb_mapper_banked.sv
// Directed plus randomized bench for mapper_banked against a slot-table reference model.
module tb_mapper_banked;
  import mapper_pkg::*;

  localparam int NMAPS = 2;
  localparam int PASS  = SLOTS + 2;

  logic                 clk = 1'b0;
  logic                 reset, ready, cfg_we, cfg_enable, cfg_commit;
  logic [15:0]          core_address_next;
  logic [MAP_W-1:0]     active_map, cfg_map;
  logic [2:0]           cfg_slot;
  logic [OFF_W-1:0]     cfg_offset, rd_offset;
  logic                 rd_enable, busy, commit_done, map_next, map;
  logic [19:0]          address_next, address;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_q[$];

  logic [11:0] m_arch_off [NMAPS][SLOTS];
  bit          m_arch_en  [NMAPS][SLOTS];
  logic [11:0] m_fast_off [NMAPS][SLOTS];
  bit          m_fast_en  [NMAPS][SLOTS];
  logic [19:0] exp_addr;
  logic        exp_map;

  mapper_banked dut (
    .clk(clk), .reset(reset), .ready(ready), .core_address_next(core_address_next),
    .active_map(active_map), .cfg_we(cfg_we), .cfg_map(cfg_map), .cfg_slot(cfg_slot),
    .cfg_offset(cfg_offset), .cfg_enable(cfg_enable), .cfg_commit(cfg_commit),
    .rd_offset(rd_offset), .rd_enable(rd_enable), .busy(busy), .commit_done(commit_done),
    .address_next(address_next), .map_next(map_next), .address(address), .map(map)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (commit_done === 1'b1) done_q.push_back(cyc);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_xlate(input int am, input logic [15:0] a);
    int s, hi;
    s = int'(a[15:13]);
    if (m_fast_en[am][s]) begin
      hi = (int'(m_fast_off[am][s]) + int'(a[15:8])) % 4096;
      return 20'(hi * 256 + int'(a[7:0]));
    end
    return {4'h0, a};
  endfunction

  task automatic snapshot(input int m);
    for (int s = 0; s < SLOTS; s++) begin
      m_fast_en[m][s]  = m_arch_en[m][s];
      m_fast_off[m][s] = m_arch_en[m][s] ? m_arch_off[m][s] : 12'h000;
    end
  endtask

  task automatic arch_write(input int m, input int s, input logic [11:0] off, input bit en,
                            input bit with_commit, output int c0);
    cfg_we = 1'b1; cfg_map = MAP_W'(m); cfg_slot = 3'(s);
    cfg_offset = off; cfg_enable = en; cfg_commit = with_commit;
    step();
    c0 = cyc;
    cfg_we = 1'b0; cfg_commit = 1'b0;
    m_arch_off[m][s] = off;
    m_arch_en[m][s]  = en;
    if (with_commit) snapshot(m);
  endtask

  task automatic do_commit(input int m, output int c0);
    cfg_map = MAP_W'(m); cfg_commit = 1'b1;
    step();
    c0 = cyc;
    cfg_commit = 1'b0;
    snapshot(m);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 300) begin
      step();
      k++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    step();
    step();
  endtask

  task automatic check_xlate(input string tag, input int am, input logic [15:0] a);
    logic [19:0] e;
    active_map = MAP_W'(am);
    core_address_next = a;
    #1;
    e = ref_xlate(am, a);
    check({tag, "_addr_next"}, {12'd0, address_next}, {12'd0, e});
    check({tag, "_map_next"}, {31'd0, map_next}, {31'd0, (e != {4'h0, a}) || m_fast_en[am][int'(a[15:13])]});
    step();
    exp_addr = e;
    exp_map  = m_fast_en[am][int'(a[15:13])];
    check({tag, "_addr_reg"}, {12'd0, address}, {12'd0, exp_addr});
    check({tag, "_map_reg"}, {31'd0, map}, {31'd0, exp_map});
  endtask

  initial begin
    int c0, c1, n, m, s;
    logic [11:0] o;
    bit e;
    logic [7:0] rst_en;

    rst_en = 8'h30;
    for (int mm = 0; mm < NMAPS; mm++) begin
      for (int ss = 0; ss < SLOTS; ss++) begin
        m_arch_en[mm][ss]  = (mm == NMAPS - 1) && rst_en[ss];
        m_arch_off[mm][ss] = m_arch_en[mm][ss] ? 12'hF00 : 12'h000;
        m_fast_en[mm][ss]  = 1'b0;
        m_fast_off[mm][ss] = 12'h000;
      end
    end
    reset = 1'b0; ready = 1'b1; core_address_next = 16'h0000; active_map = '0;
    cfg_we = 1'b0; cfg_map = '0; cfg_slot = 3'd0; cfg_offset = 12'h000;
    cfg_enable = 1'b0; cfg_commit = 1'b0;
    exp_addr = 20'h00000; exp_map = 1'b0;

    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_address", {12'd0, address}, 32'd0);
    check("rst_map", {31'd0, map}, 32'd0);
    check("rst_commit_done", {31'd0, commit_done}, 32'd0);
    cfg_map = 1'b1; cfg_slot = 3'd5; #1;
    check("rst_rd_off_m1s5", {20'd0, rd_offset}, {20'd0, m_arch_off[1][5]});
    check("rst_rd_en_m1s5", {31'd0, rd_enable}, {31'd0, m_arch_en[1][5]});
    cfg_map = 1'b0; cfg_slot = 3'd4; #1;
    check("rst_rd_en_m0s4", {31'd0, rd_enable}, {31'd0, m_arch_en[0][4]});

    // Boot refresh of every map: busy for NUM_MAPS*(SLOTS+1) cycles, silently.
    done_q.delete();
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy !== 1'b1) break;
      n++;
      step();
    end
    check("boot_busy_cycles", n, NMAPS * (SLOTS + 1));
    check("boot_no_done", done_q.size(), 0);
    snapshot(0);
    snapshot(1);
    check_xlate("boot_m1", 1, 16'h8123);
    check_xlate("boot_m0", 0, 16'h8123);

    // Single commit of map0 slot2.
    arch_write(0, 2, 12'h123, 1'b1, 1'b0, c0);
    done_q.delete();
    do_commit(0, c0);
    check("commit_busy_rise", {31'd0, busy}, 32'd1);
    wait_idle();
    check("commit_done_count", done_q.size(), 1);
    check("commit_done_latency", done_q[0] - c0, PASS);
    check_xlate("slot2", 0, 16'h4567);

    // Offset add wraps modulo the physical space.
    arch_write(0, 7, 12'hFFF, 1'b1, 1'b0, c0);
    do_commit(0, c0);
    wait_idle();
    check_xlate("wrap", 0, 16'hE010);

    // Recommit of the map being refreshed restarts the pass.
    done_q.delete();
    do_commit(0, c0);
    step();
    step();
    do_commit(0, c1);
    wait_idle();
    check("recommit_count", done_q.size(), 1);
    check("recommit_latency", done_q[0] - c0, (c1 - c0) + PASS);

    // Commit of another map during a refresh queues a second pass.
    arch_write(1, 6, 12'h0AB, 1'b1, 1'b0, c0);
    check_xlate("m1_stale", 1, 16'hC234);
    done_q.delete();
    do_commit(0, c0);
    step();
    step();
    do_commit(1, c1);
    wait_idle();
    check("two_pass_count", done_q.size(), 2);
    check("two_pass_first", done_q[0] - c0, PASS);
    check("two_pass_second", done_q[1] - c0, 2 * PASS);
    check_xlate("m1_fresh", 1, 16'hC234);

    // Stalled CPU cycles hold the registered translation.
    check_xlate("pre_hold", 0, 16'h4001);
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      core_address_next = 16'($urandom);
      active_map = 1'($urandom);
      #1;
      check("hold_addr_next", {12'd0, address_next}, {12'd0, exp_addr});
      check("hold_map_next", {31'd0, map_next}, {31'd0, exp_map});
      step();
      check("hold_addr_reg", {12'd0, address}, {12'd0, exp_addr});
      check("hold_map_reg", {31'd0, map}, {31'd0, exp_map});
    end
    ready = 1'b1;

    // Write and commit in the same cycle.
    arch_write(1, 3, 12'h055, 1'b1, 1'b1, c0);
    wait_idle();
    check_xlate("we_commit", 1, 16'h6F0E);

    // Randomized writes, readback, commits and translations.
    for (int it = 0; it < 16; it++) begin
      n = $urandom_range(1, 4);
      for (int w = 0; w < n; w++) begin
        m = $urandom_range(0, NMAPS - 1);
        s = $urandom_range(0, SLOTS - 1);
        o = 12'($urandom);
        e = 1'($urandom);
        arch_write(m, s, o, e, 1'b0, c0);
        check("rand_rd_offset", {20'd0, rd_offset}, {20'd0, o});
        check("rand_rd_enable", {31'd0, rd_enable}, {31'd0, e});
      end
      if ($urandom_range(0, 2) != 0) begin
        do_commit($urandom_range(0, NMAPS - 1), c0);
        wait_idle();
      end
      for (int t = 0; t < 6; t++) begin
        check_xlate("rand", $urandom_range(0, NMAPS - 1), 16'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
